diff_clk_fwd: RTL and testbench
===============================

# diff_clk_fwd

Multi-channel forwarded-clock generator with differential outputs. Each of NCH channels divides the fabric clock by a programmable even ratio and produces a 50 % duty, glitch-free clock. Starts and stops are clean, and each channel drives its own OBUFDS pair to top-level pins. It replaces single-channel, always-on differential clock buffers wherever board-level clocks must be gated, rate-selected or start-aligned.

## Interface
Parameters:
- NCH, 4, number of output channels
- DIV_W, 8, width of each half-period divisor field
- IOSTANDARD, "DEFAULT", passed to every OBUFDS
- SLEW, "SLOW", passed to every OBUFDS

Ports:
- clk  in  1  fabric clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  NCH  per-channel run request, level-sensitive
- div  in  NCH*DIV_W  per-channel half-period minus one; channel k uses bits [k*DIV_W +: DIV_W]
- sync_start  in  1  common start strobe; present only with DIFFCLK_SYNC_START_EN
- running  out  NCH  channel state is not IDLE
- clk_p  out  NCH  differential positive, to pins
- clk_n  out  NCH  differential negative, to pins

## Operation
- Per channel: registered output bit `q`, half-period counter `cnt` (DIV_W bits), latched divisor `dq`, and a 3-state FSM.
- States and transitions:
  - IDLE: q=0, cnt=0. Go to RUN when the start condition is true; on that edge set q=1, cnt=0, dq=div[k].
  - RUN: cnt increments each cycle. When cnt==dq: toggle q and clear cnt. If q is 0 at that point (rising toggle), reload dq from div[k]. If en[k]=0, go to STOPPING.
  - STOPPING: keep counting. Complete the current high phase (if any), then one full low phase of dq+1 cycles, then go to IDLE. en is ignored in this state.
- Divisor changes take effect only at the next rising edge of q. The high and low phases of one period always use the same dq.
- Period is 2*(dq+1) clk cycles; high and low are dq+1 cycles each. div=0 gives clk/2.
- No high pulse is ever shorter than dq+1 cycles. No low gap between restarts is ever shorter than dq+1 cycles.
- Counter arithmetic is unsigned DIV_W bits. cnt never exceeds dq, so there is no wrap.
- Each q bit drives one OBUFDS instance: O→clk_p[k], OB→clk_n[k], with the IOSTANDARD and SLEW parameters.
- Channels are independent except for the shared sync_start.

## Timing
- Reset values: q=0 (clk_p=0, clk_n=1), running=0, all FSMs IDLE, cnt=0, dq=0.
- Reset asserted mid-operation forces reset values immediately and asynchronously. A truncated pulse is permitted only on reset.
- Start latency: start condition sampled true at edge t; q=1 and running=1 after edge t.
- Stop: en sampled low at edge t during RUN. running falls on the same edge that ends the final low phase.
- en re-asserted while STOPPING: the channel restarts one edge after reaching IDLE, provided the start condition holds then.
- en deasserted and re-asserted within the same RUN high phase: no effect on the output.

## Configuration
- DIFFCLK_SYNC_START_EN defined:
  - sync_start port exists.
  - Start condition is en[k] && sync_start, sampled on the same edge.
  - All channels enabled before a sync_start pulse start on that same edge. Outputs with equal div stay phase-aligned.
- DIFFCLK_SYNC_START_EN undefined:
  - No sync_start port.
  - Start condition is en[k] alone.

## Test plan
- Reset release with en=0: clk_p=0, clk_n=1, running=0 held for 20 cycles.
- Channel 0, div=0, en=1 at cycle 10: clk_p[0] toggles every cycle from cycle 11 (period 2); running[0]=1 from cycle 11.
- Channel 1, div=3: period 8, 4 high / 4 low. Change div to 1 mid-high: the current period stays 4/4, then 2/2 starting from the next rising edge.
- Channel 2, div=3, drop en on the 2nd cycle of a high phase: 2 more high cycles, then 4 low, then running[2]=0. Pulse en for 1 cycle during STOPPING: no effect.
- With DIFFCLK_SYNC_START_EN: en[0] set at cycle 5, en[3] set at cycle 9, sync_start pulse at cycle 12, both div=2. Both channels go high after edge 12 and stay edge-aligned; neither starts before sync_start.
- Assert rst for 1 cycle mid high phase on all channels: all outputs immediately 0/1 and running=0. Channels restart cleanly after release with en still high.

Source files
------------

// File: rtl/diff_clk_fwd_if.sv
// Bundle for diff_clk_fwd: per-channel run requests, divisors, status and differential pin pairs.
// DIFFCLK_SYNC_START_EN adds the shared sync_start strobe.
interface diff_clk_fwd_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIV_W = 8
);
  logic [NCH-1:0]       en;
  logic [NCH*DIV_W-1:0] div;
`ifdef DIFFCLK_SYNC_START_EN
  logic                 sync_start;
`endif
  logic [NCH-1:0]       running;
  logic [NCH-1:0]       clk_p;
  logic [NCH-1:0]       clk_n;

`ifdef DIFFCLK_SYNC_START_EN
  modport master (output en, div, sync_start, input running, clk_p, clk_n);
  modport slave  (input en, div, sync_start, output running, clk_p, clk_n);
`else
  modport master (output en, div, input running, clk_p, clk_n);
  modport slave  (input en, div, output running, clk_p, clk_n);
`endif
endinterface

// File: rtl/diff_clk_fwd.sv
// Multi-channel forwarded clock: per-channel even divider with clean start/stop driving OBUFDS pairs.
// Optional DIFFCLK_SYNC_START_EN makes every start wait for the shared sync_start strobe.
module diff_clk_fwd #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DIV_W      = 8,
  parameter string       IOSTANDARD = "DEFAULT",
  parameter string       SLEW       = "SLOW"
) (
  input  logic          clk,
  input  logic          rst,
  diff_clk_fwd_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  logic [NCH-1:0] q_all;
  logic [NCH-1:0] run_all;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             q;
    logic             q_nx;
    logic             run;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W-1:0] dq;
    logic [DIV_W-1:0] dq_nx;
    logic [DIV_W-1:0] div_k;
    logic             en_k;
    logic             start_c;
    logic             wrap_c;

    assign div_k  = bus.div[k*DIV_W +: DIV_W];
    assign en_k   = bus.en[k];
    assign wrap_c = (cnt == dq);
`ifdef DIFFCLK_SYNC_START_EN
    assign start_c = en_k & bus.sync_start;
`else
    assign start_c = en_k;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q   <= 1'b0;
        cnt <= '0;
        dq  <= '0;
        run <= 1'b0;
      end else begin
        q   <= q_nx;
        cnt <= cnt_nx;
        dq  <= dq_nx;
        run <= (state_nx != IDLE);
      end
    end

    // A stop is committed only inside a low phase or at the end of a high phase,
    // so an en dip that recovers within one high phase leaves the output untouched.
    always_comb begin
      state_nx = state;
      q_nx     = q;
      cnt_nx   = cnt + DIV_W'(1);
      dq_nx    = dq;
      case (state)
        IDLE: begin
          q_nx   = 1'b0;
          cnt_nx = '0;
          if (start_c) begin
            state_nx = RUN;
            q_nx     = 1'b1;
            dq_nx    = div_k;
          end
        end
        RUN: begin
          if (wrap_c) begin
            q_nx   = ~q;
            cnt_nx = '0;
            if (!q) dq_nx = div_k;
          end
          if (!en_k && (q == wrap_c)) state_nx = STOPPING;
        end
        STOPPING: begin
          if (wrap_c) begin
            q_nx   = 1'b0;
            cnt_nx = '0;
            if (!q) state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          q_nx     = 1'b0;
          cnt_nx   = '0;
        end
      endcase
    end

    assign q_all[k]   = q;
    assign run_all[k] = run;
  end

  assign bus.running = run_all;

`ifdef SYNTHESIS
  for (genvar k = 0; k < NCH; k++) begin : g_obuf
    OBUFDS #(
      .IOSTANDARD (IOSTANDARD),
      .SLEW       (SLEW)
    ) u_obufds (
      .I  (q_all[k]),
      .O  (bus.clk_p[k]),
      .OB (bus.clk_n[k])
    );
  end
`else
  // Behavioural stand-in for the pad buffers; pad attributes only matter to the vendor primitive.
  logic unused_cfg;
  assign unused_cfg = (IOSTANDARD == "") ^ (SLEW == "");
  assign bus.clk_p  = q_all;
  assign bus.clk_n  = ~q_all;
`endif

endmodule

// File: tb/tb_diff_clk_fwd.sv
// Scoreboard bench for diff_clk_fwd: expected per-cycle {q,running} per channel queued at stimulus time.
// Covers the sync-start scenario when DIFFCLK_SYNC_START_EN is defined.
module tb_diff_clk_fwd;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DIV_W = 8;

  logic  clk;
  logic  rst;
  int    n_cmp = 0;
  int    n_err = 0;
  string tag   = "init";

  logic [1:0] sb0[$];
  logic [1:0] sb1[$];
  logic [1:0] sb2[$];
  logic [1:0] sb3[$];

  diff_clk_fwd_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

  diff_clk_fwd #(
    .NCH        (NCH),
    .DIV_W      (DIV_W),
    .IOSTANDARD ("LVDS_25"),
    .SLEW       ("SLOW")
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", t, $time, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic q, input logic run, input int n);
    for (int i = 0; i < n; i++) begin
      case (ch)
        0: sb0.push_back({q, run});
        1: sb1.push_back({q, run});
        2: sb2.push_back({q, run});
        default: sb3.push_back({q, run});
      endcase
    end
  endtask

  // Full periods of a running channel: d+1 high cycles then d+1 low cycles.
  task automatic push_run(input int ch, input int d, input int nper);
    for (int p = 0; p < nper; p++) begin
      push(ch, 1'b1, 1'b1, d + 1);
      push(ch, 1'b0, 1'b1, d + 1);
    end
  endtask

  // An empty queue means the channel is expected idle.
  function automatic logic [1:0] pop(input int ch);
    logic [1:0] v;
    v = 2'b00;
    case (ch)
      0: if (sb0.size() > 0) v = sb0.pop_front();
      1: if (sb1.size() > 0) v = sb1.pop_front();
      2: if (sb2.size() > 0) v = sb2.pop_front();
      default: if (sb3.size() > 0) v = sb3.pop_front();
    endcase
    return v;
  endfunction

  task automatic tick();
    logic [NCH-1:0] eq;
    logic [NCH-1:0] er;
    logic [1:0]     e;
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      e     = pop(k);
      eq[k] = e[1];
      er[k] = e[0];
    end
    check(tag, 32'({bus.clk_p, bus.clk_n, bus.running}), 32'({eq, ~eq, er}));
`ifdef DIFFCLK_SYNC_START_EN
    bus.sync_start = 1'b0;
`endif
  endtask

  task automatic start_ch(input int ch, input int d);
    bus.div[ch*DIV_W +: DIV_W] = DIV_W'(d);
    bus.en[ch] = 1'b1;
`ifdef DIFFCLK_SYNC_START_EN
    bus.sync_start = 1'b1;
`endif
  endtask

  initial begin
    rst     = 1'b1;
    bus.en  = '0;
    bus.div = '0;
`ifdef DIFFCLK_SYNC_START_EN
    bus.sync_start = 1'b0;
`endif
    tag = "reset";
    repeat (2) tick();
    rst = 1'b0;
    tag = "idle_after_reset";
    repeat (20) tick();

    // Channel 0 at clk/2, then stop on a low-phase boundary.
    tag = "ch0_div0";
    start_ch(0, 0);
    push_run(0, 0, 6);
    repeat (12) tick();
    bus.en[0] = 1'b0;
    push(0, 1'b1, 1'b1, 1);
    push(0, 1'b0, 1'b1, 1);
    repeat (4) tick();

    // Channel 1: divisor change mid-high only applies from the next rising edge.
    tag = "ch1_div3";
    start_ch(1, 3);
    push_run(1, 3, 1);
    repeat (2) tick();
    tag = "ch1_div1";
    bus.div[1*DIV_W +: DIV_W] = DIV_W'(1);
    push_run(1, 1, 3);
    repeat (18) tick();
    bus.en[1] = 1'b0;
    push(1, 1'b1, 1'b1, 2);
    push(1, 1'b0, 1'b1, 2);
    repeat (6) tick();

    // Channel 2: en dropped on the 2nd high cycle, then a 1-cycle en pulse while stopping.
    tag = "ch2_stop";
    start_ch(2, 3);
    push_run(2, 3, 1);
    push(2, 1'b1, 1'b1, 4);
    repeat (10) tick();
    bus.en[2] = 1'b0;
    push(2, 1'b0, 1'b1, 4);
    repeat (3) tick();
    bus.en[2] = 1'b1;
    tick();
    bus.en[2] = 1'b0;
    repeat (6) tick();

    // Channel 3: en dip within one high phase must not disturb the output.
    tag = "ch3_glitch";
    start_ch(3, 2);
    push_run(3, 2, 3);
    repeat (7) tick();
    bus.en[3] = 1'b0;
    tick();
    bus.en[3] = 1'b1;
    repeat (10) tick();
    bus.en[3] = 1'b0;
    push(3, 1'b1, 1'b1, 3);
    push(3, 1'b0, 1'b1, 3);
    repeat (8) tick();

`ifdef DIFFCLK_SYNC_START_EN
    // Channels 0 and 3 wait for sync_start, then run edge-aligned.
    tag = "sync_wait";
    bus.div[0*DIV_W +: DIV_W] = DIV_W'(2);
    bus.div[3*DIV_W +: DIV_W] = DIV_W'(2);
    bus.en[0] = 1'b1;
    repeat (4) tick();
    bus.en[3] = 1'b1;
    repeat (3) tick();
    tag = "sync_go";
    bus.sync_start = 1'b1;
    push_run(0, 2, 3);
    push_run(3, 2, 3);
    repeat (18) tick();
    bus.en[0] = 1'b0;
    bus.en[3] = 1'b0;
    push(0, 1'b1, 1'b1, 3);
    push(0, 1'b0, 1'b1, 3);
    push(3, 1'b1, 1'b1, 3);
    push(3, 1'b0, 1'b1, 3);
    repeat (8) tick();
`endif

    // Reset mid high phase on every channel, then clean restart with en still high.
    tag = "rst_mid_high";
    for (int k = 0; k < NCH; k++) begin
      start_ch(k, 3);
      push(k, 1'b1, 1'b1, 2);
    end
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 32'({bus.clk_p, bus.clk_n, bus.running}), 32'({4'h0, 4'hF, 4'h0}));
    tag = "rst_held";
    tick();
    rst = 1'b0;
`ifdef DIFFCLK_SYNC_START_EN
    bus.sync_start = 1'b1;
`endif
    tag = "restart";
    for (int k = 0; k < NCH; k++) push_run(k, 3, 1);
    repeat (8) tick();
    bus.en = '0;
    for (int k = 0; k < NCH; k++) begin
      push(k, 1'b1, 1'b1, 4);
      push(k, 1'b0, 1'b1, 4);
    end
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
